// File: rtl/nq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nq_pkg
// Description : Shared constants, controller state encoding and frame byte
//               selection for the N-Queens sweep reporter.
// Revision    : 1.0 - initial release
// ============================================================================
package nq_pkg;

  localparam logic [7:0] FRAME_HDR   = 8'hA5;
  localparam int         FRAME_BYTES = 5;
  localparam int         SUM_W       = 24;
  localparam int         N_W         = 5;
  localparam logic [SUM_W-1:0] TIMEOUT_SUM = 24'hFFFFFF;

  // Controller state encoding
  localparam int ST_W = 3;
  typedef logic [ST_W-1:0] nq_state_t;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ACC_RST = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_LATCH   = 3'd3;
  localparam logic [2:0] ST_TX_LOAD = 3'd4;
  localparam logic [2:0] ST_TX_WAIT = 3'd5;
  localparam logic [2:0] ST_NEXT    = 3'd6;
  localparam logic [2:0] ST_FINISH  = 3'd7;

  // Picks byte idx out of a frame packed with byte 0 in the low bits.
  function automatic logic [7:0] frame_byte(input logic [FRAME_BYTES*8-1:0] frame,
                                            input logic [2:0]               idx);
    logic [7:0] b;
    case (idx)
      3'd1:    b = frame[15:8];
      3'd2:    b = frame[23:16];
      3'd3:    b = frame[31:24];
      3'd4:    b = frame[39:32];
      default: b = frame[7:0];
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nq_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : nq_uart_tx
// Description : 8N1 UART transmitter, LSB first. tx_busy rises the cycle after
//               an accepted tx_start and falls as the stop bit ends.
// Revision    : 1.0 - initial release
// ============================================================================
module nq_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       tx_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // shift_q[0] is the bit on the line; ones shift in so the line idles high.
  logic [9:0]       shift_q, shift_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic             busy_q, busy_d;

  // Bit timing and shift sequencing; start requests while busy are dropped.
  always_comb begin
    shift_d   = shift_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    busy_d    = busy_q;
    if (!busy_q) begin
      if (tx_start) begin
        shift_d   = {1'b1, tx_data, 1'b0};
        busy_d    = 1'b1;
        clk_cnt_d = '0;
        bit_idx_d = 4'd0;
      end
    end else if (clk_cnt_q == CNT_LAST) begin
      clk_cnt_d = '0;
      shift_d   = {1'b1, shift_q[9:1]};
      if (bit_idx_q == 4'd9) begin
        busy_d    = 1'b0;
        bit_idx_d = 4'd0;
      end else begin
        bit_idx_d = bit_idx_q + 4'd1;
      end
    end else begin
      clk_cnt_d = clk_cnt_q + 1'b1;
    end
  end

  // State registers; reset forces the line high, truncating any byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q   <= '1;
      clk_cnt_q <= '0;
      bit_idx_q <= 4'd0;
      busy_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      busy_q    <= busy_d;
    end
  end

  assign txd     = shift_q[0];
  assign tx_busy = busy_q;

endmodule
`default_nettype wire

// File: rtl/nq_sweep_reporter.sv
`default_nettype none
// ============================================================================
// Module      : nq_sweep_reporter
// Description : Sweeps board size N_MIN..N_MAX through the N-Queens
//               accelerator and reports each count as a 5-byte UART frame
//               (A5, n, sum[23:16], sum[15:8], sum[7:0]).
//               Define NQ_TIMEOUT_EN to add a RUN watchdog that reports
//               FF FF FF after TIMEOUT_CYCLES without acc_done.
// Revision    : 1.0 - initial release
// ============================================================================
module nq_sweep_reporter
  import nq_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 868,
  parameter int N_MIN          = 4,
  parameter int N_MAX          = 16,
  parameter int RST_CYCLES     = 25,
  parameter int TIMEOUT_CYCLES = 2**26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [N_W-1:0]   acc_n,
  output logic             acc_reset,
  input  logic [SUM_W-1:0] acc_sum,
  input  logic             acc_done,
  output logic             uart_txd,
  output logic             busy,
  output logic             sweep_done
);

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [N_W-1:0]   N_FIRST  = N_W'(N_MIN);
  localparam logic [N_W-1:0]   N_LAST   = N_W'(N_MAX);
  localparam logic [2:0]       IDX_LAST = 3'(FRAME_BYTES - 1);

  nq_state_t                state_q, state_d;
  logic [N_W-1:0]           cur_n_q, cur_n_d;
  logic [RST_W-1:0]         rst_cnt_q, rst_cnt_d;
  logic [2:0]               idx_q, idx_d;
  logic [FRAME_BYTES*8-1:0] frame_q, frame_d;

  logic             tx_start;
  logic             tx_busy;
  logic [7:0]       tx_data;
  logic             timeout_hit;
  logic [SUM_W-1:0] sum_sel;

`ifdef NQ_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] wd_q, wd_d;
  logic        timed_out_q, timed_out_d;

  // Watchdog: cleared while the accelerator is held in reset, counts in RUN.
  always_comb begin
    wd_d        = wd_q;
    timed_out_d = timed_out_q;
    if (state_q == ST_ACC_RST) begin
      wd_d        = '0;
      timed_out_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      wd_d = wd_q + 32'd1;
      if (!acc_done && (wd_q == WD_LAST)) begin
        timed_out_d = 1'b1;
      end
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_q        <= '0;
      timed_out_q <= 1'b0;
    end else begin
      wd_q        <= wd_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign timeout_hit = (state_q == ST_RUN) && (wd_q == WD_LAST);
  assign sum_sel     = timed_out_q ? TIMEOUT_SUM : acc_sum;
`else
  assign timeout_hit = 1'b0;
  assign sum_sel     = acc_sum;
`endif

  // Sweep controller: reset/run each board size, then ship its frame.
  always_comb begin
    state_d   = state_q;
    cur_n_d   = cur_n_q;
    rst_cnt_d = rst_cnt_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    tx_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_n_d   = N_FIRST;
          rst_cnt_d = '0;
          state_d   = ST_ACC_RST;
        end
      end
      ST_ACC_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (acc_done || timeout_hit) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        frame_d = {sum_sel[7:0], sum_sel[15:8], sum_sel[23:16],
                   {3'b000, cur_n_q}, FRAME_HDR};
        idx_d   = 3'd0;
        state_d = ST_TX_LOAD;
      end
      ST_TX_LOAD: begin
        tx_start = 1'b1;
        state_d  = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        // tx_busy is already high on entry, so a low level marks the fall.
        if (!tx_busy) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_NEXT;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_TX_LOAD;
          end
        end
      end
      ST_NEXT: begin
        if (cur_n_q == N_LAST) begin
          state_d = ST_FINISH;
        end else begin
          cur_n_d   = cur_n_q + 1'b1;
          rst_cnt_d = '0;
          state_d   = ST_ACC_RST;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cur_n_q   <= N_FIRST;
      rst_cnt_q <= '0;
      idx_q     <= 3'd0;
      frame_q   <= '0;
    end else begin
      state_q   <= state_d;
      cur_n_q   <= cur_n_d;
      rst_cnt_q <= rst_cnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
    end
  end

  assign tx_data    = frame_byte(frame_q, idx_q);
  assign acc_n      = cur_n_q;
  assign acc_reset  = (state_q == ST_IDLE) || (state_q == ST_ACC_RST) ||
                      (state_q == ST_FINISH);
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign sweep_done = (state_q == ST_FINISH);

  nq_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk     (clk),
    .reset   (reset),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .txd     (uart_txd),
    .tx_busy (tx_busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_nq_sweep_reporter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_nq_sweep_reporter
// Description : Self-checking bench: three reporters (n=8, n=4..5, n=16)
//               against a behavioural accelerator and a UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nq_sweep_reporter;

  localparam int CPB  = 4;
  localparam int RSTC = 25;
  localparam int TMO  = 100;
  localparam int NI   = 3;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [NI-1:0] start  = '0;
  logic [NI-1:0] glitch = '0;
  logic [NI-1:0] hold   = '0;
  logic [4:0]    acc_n   [NI];
  logic [23:0]   acc_sum [NI];
  logic [NI-1:0] acc_reset, acc_done, uart_txd, busy, sweep_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nq_sweep_reporter #(.CLKS_PER_BIT(CPB), .N_MIN(8), .N_MAX(8), .RST_CYCLES(RSTC),
                      .TIMEOUT_CYCLES(TMO)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .acc_n(acc_n[0]),
    .acc_reset(acc_reset[0]), .acc_sum(acc_sum[0]), .acc_done(acc_done[0]),
    .uart_txd(uart_txd[0]), .busy(busy[0]), .sweep_done(sweep_done[0]));

  nq_sweep_reporter #(.CLKS_PER_BIT(CPB), .N_MIN(4), .N_MAX(5), .RST_CYCLES(RSTC),
                      .TIMEOUT_CYCLES(TMO)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .acc_n(acc_n[1]),
    .acc_reset(acc_reset[1]), .acc_sum(acc_sum[1]), .acc_done(acc_done[1]),
    .uart_txd(uart_txd[1]), .busy(busy[1]), .sweep_done(sweep_done[1]));

  nq_sweep_reporter #(.CLKS_PER_BIT(CPB), .N_MIN(16), .N_MAX(16), .RST_CYCLES(RSTC),
                      .TIMEOUT_CYCLES(TMO)) dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .acc_n(acc_n[2]),
    .acc_reset(acc_reset[2]), .acc_sum(acc_sum[2]), .acc_done(acc_done[2]),
    .uart_txd(uart_txd[2]), .busy(busy[2]), .sweep_done(sweep_done[2]));

  // ---------------- accelerator model ----------------
  function automatic logic [23:0] model_sum(input logic [4:0] n);
    case (n)
      5'd4:    return 24'd2;
      5'd5:    return 24'd10;
      5'd8:    return 24'd92;
      5'd16:   return 24'hE16920;
      default: return 24'd0;
    endcase
  endfunction

  int            mcnt [NI];
  logic [NI-1:0] mdone;

  // done rises three cycles after acc_reset falls (unless held off)
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (acc_reset[i]) begin
        mcnt[i]  <= 0;
        mdone[i] <= 1'b0;
      end else begin
        if (mcnt[i] < 7) mcnt[i] <= mcnt[i] + 1;
        if (mcnt[i] == 2 && !hold[i]) mdone[i] <= 1'b1;
      end
    end
  end

  // sum is valid only in the done cycle and the one after it
  always_comb begin
    for (int i = 0; i < NI; i++) begin
      acc_done[i] = mdone[i] | glitch[i];
      acc_sum[i]  = (mdone[i] && (mcnt[i] == 3 || mcnt[i] == 4)) ? model_sum(acc_n[i])
                                                                  : 24'h5A5A5A;
    end
  end

  // ---------------- monitors ----------------
  typedef struct { int inst; logic [7:0] data; int t; } rx_t;
  typedef struct { int inst; int len; int tfall; } rst_t;
  rx_t  rxlog[$];
  rst_t rstlog[$];

  logic [NI-1:0] rx_act = '0, rx_bit = '0, prev_rst = '1, prev_sd = '0;
  int            rx_pos [NI];
  int            rx_t0  [NI];
  logic [7:0]    rx_byte[NI];
  int            hi_len [NI];
  int            bit_err[NI];
  int            sd_cnt [NI];
  int            sd_bad [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int k;
      if (!reset) begin
        rx_act[i]   = 1'b0;
        hi_len[i]   = 0;
        prev_rst[i] = 1'b1;
        prev_sd[i]  = 1'b0;
      end else begin
        // UART receiver: every bit must hold for exactly CPB cycles
        if (!rx_act[i]) begin
          if (uart_txd[i] == 1'b0) begin
            rx_act[i]  = 1'b1;
            rx_pos[i]  = 1;
            rx_bit[i]  = 1'b0;
            rx_t0[i]   = cyc;
            rx_byte[i] = 8'h00;
          end
        end else begin
          if (rx_pos[i] % CPB == 0) begin
            k = rx_pos[i] / CPB;
            rx_bit[i] = uart_txd[i];
            if (k >= 1 && k <= 8) rx_byte[i][k-1] = uart_txd[i];
            if (k == 9 && uart_txd[i] !== 1'b1) bit_err[i]++;
          end else if (uart_txd[i] !== rx_bit[i]) begin
            bit_err[i]++;
          end
          if (rx_pos[i] == 10*CPB - 1) begin
            rxlog.push_back('{i, rx_byte[i], rx_t0[i]});
            rx_act[i] = 1'b0;
          end else begin
            rx_pos[i]++;
          end
        end
        // accelerator reset pulse lengths while busy
        if (acc_reset[i] && busy[i]) hi_len[i]++;
        if (prev_rst[i] && !acc_reset[i]) begin
          rstlog.push_back('{i, hi_len[i], cyc});
          hi_len[i] = 0;
        end
        prev_rst[i] = acc_reset[i];
        // sweep_done must be a single-cycle pulse with busy low
        if (sweep_done[i]) begin
          sd_cnt[i]++;
          if (prev_sd[i] || busy[i]) sd_bad[i]++;
        end
        prev_sd[i] = sweep_done[i];
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int              inst;
    bit              noise;
    bit              hold;
    int              nframes;
    logic [0:9][7:0] exp;
  } vec_t;

  function automatic vec_t mk(input int inst, input bit noise, input bit hl,
                              input int nf, input logic [0:9][7:0] exp);
    vec_t v;
    v.inst = inst; v.noise = noise; v.hold = hl; v.nframes = nf; v.exp = exp;
    return v;
  endfunction

  task automatic run_vec(input int vi, input vec_t v);
    int  inst;
    bit  seen;
    int  nb;
    inst = v.inst;
    rxlog.delete();
    rstlog.delete();
    sd_cnt[inst] = 0; sd_bad[inst] = 0; bit_err[inst] = 0;
    hold[inst] = v.hold;
    start[inst] = 1'b1;
    tick();
    start[inst] = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20000 && !seen; t++) begin
      if (v.noise) begin
        glitch[inst] = (t == 4);
        start[inst]  = (t == 10 || t == 60 || t == 150);
      end
      tick();
      if (sweep_done[inst]) seen = 1'b1;
    end
    glitch[inst] = 1'b0;
    start[inst]  = 1'b0;
    chk($sformatf("v%0d sweep_done seen", vi), 64'(seen), 64'd1);
    if (v.noise) begin
      start[inst] = 1'b1;          // sampled while in FINISH: must be ignored
      tick();
      start[inst] = 1'b0;
    end
    repeat (4) tick();
    chk($sformatf("v%0d busy after sweep", vi), 64'(busy[inst]), 64'd0);
    hold[inst] = 1'b0;

    nb = v.nframes * 5;
    chk($sformatf("v%0d byte count", vi), 64'(rxlog.size()), 64'(nb));
    for (int k = 0; k < nb && k < rxlog.size(); k++) begin
      chk($sformatf("v%0d byte %0d", vi, k), 64'(rxlog[k].data), 64'(v.exp[k]));
      if (k % 5 != 0)
        chk($sformatf("v%0d byte %0d start spacing", vi, k),
            64'(rxlog[k].t - rxlog[k-1].t), 64'(10*CPB + 2));
    end
    chk($sformatf("v%0d acc_reset pulses", vi), 64'(rstlog.size()), 64'(v.nframes));
    for (int k = 0; k < rstlog.size(); k++)
      chk($sformatf("v%0d acc_reset len %0d", vi, k), 64'(rstlog[k].len), 64'(RSTC));
    if (rstlog.size() > 0 && rxlog.size() > 0)
      chk($sformatf("v%0d run-to-first-start", vi), 64'(rxlog[0].t - rstlog[0].tfall),
          v.hold ? 64'(TMO + 2) : 64'd6);
    chk($sformatf("v%0d sweep_done pulses", vi), 64'(sd_cnt[inst]), 64'd1);
    chk($sformatf("v%0d sweep_done shape", vi), 64'(sd_bad[inst]), 64'd0);
    chk($sformatf("v%0d uart bit timing", vi), 64'(bit_err[inst]), 64'd0);
  endtask

  // ---------------- test ----------------
  vec_t vecs[$];
  logic [4:0] nmin_exp [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      bit_err[i] = 0; sd_cnt[i] = 0; sd_bad[i] = 0; hi_len[i] = 0; rx_pos[i] = 0;
    end
    nmin_exp[0] = 5'd8; nmin_exp[1] = 5'd4; nmin_exp[2] = 5'd16;

    vecs.push_back(mk(0, 1'b0, 1'b0, 1,
      {8'hA5, 8'h08, 8'h00, 8'h00, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}));
    vecs.push_back(mk(1, 1'b0, 1'b0, 2,
      {8'hA5, 8'h04, 8'h00, 8'h00, 8'h02, 8'hA5, 8'h05, 8'h00, 8'h00, 8'h0A}));
    vecs.push_back(mk(2, 1'b0, 1'b0, 1,
      {8'hA5, 8'h10, 8'hE1, 8'h69, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}));
    vecs.push_back(mk(0, 1'b1, 1'b0, 1,
      {8'hA5, 8'h08, 8'h00, 8'h00, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}));
`ifdef NQ_TIMEOUT_EN
    vecs.push_back(mk(0, 1'b0, 1'b1, 1,
      {8'hA5, 8'h08, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}));
`endif

    // reset state
    reset = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst%0d uart_txd", i),   64'(uart_txd[i]),   64'd1);
      chk($sformatf("rst%0d acc_reset", i),  64'(acc_reset[i]),  64'd1);
      chk($sformatf("rst%0d busy", i),       64'(busy[i]),       64'd0);
      chk($sformatf("rst%0d sweep_done", i), 64'(sweep_done[i]), 64'd0);
      chk($sformatf("rst%0d acc_n", i),      64'(acc_n[i]),      64'(nmin_exp[i]));
    end
    reset = 1'b1;
    repeat (2) tick();

    for (int vi = 0; vi < vecs.size(); vi++) begin
      run_vec(vi, vecs[vi]);
      repeat (3) tick();
    end

    // reset during the 3rd byte of the second frame, then a clean restart
    rxlog.delete();
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int t = 0; t < 5000 && rxlog.size() < 7; t++) tick();
    chk("abort reached byte 8", 64'(rxlog.size() >= 7), 64'd1);
    repeat (6) tick();
    chk("abort mid-byte", 64'(rx_act[1]), 64'd1);
    reset = 1'b0;
    tick();
    chk("abort uart_txd",  64'(uart_txd[1]),  64'd1);
    chk("abort acc_reset", 64'(acc_reset[1]), 64'd1);
    chk("abort busy",      64'(busy[1]),      64'd0);
    chk("abort acc_n",     64'(acc_n[1]),     64'd4);
    reset = 1'b1;
    repeat (3) tick();
    run_vec(99, vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
